// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM encoding, SPI mode
// constants and a constant-foldable ceil(log2) helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_master_gen_if.sv
// Host-side request/response bundle of the SPI master; the host drives the
// master modport, the SPI master itself takes the slave modport.
interface spi_master_gen_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 1
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output start, tx_data, cs_sel, cpol, cpha,
    input  rx_data, rx_valid, busy
  );

  modport slave (
    input  start, tx_data, cs_sel, cpol, cpha,
    output rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer: counts CLK_DIV enabled cycles and flags the last one so
// the master can advance its phase on that edge.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CNT_W = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, wrap on tick, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick_o) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: DATA_W-bit MSB-first transfers in any SPI mode,
// NUM_CS chip selects, CS lead/trail of one half-period, one-cycle rx_valid.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 1,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_master_gen_if.slave   host,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic [NUM_CS-1:0] spi_csn,
  input  logic              spi_miso
);
  localparam int CS_W  = (clog2(NUM_CS) < 1) ? 1 : clog2(NUM_CS);
  localparam int BIT_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [NUM_CS-1:0] csn_q, csn_d;
  logic phase_q, phase_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, rx_valid_q, rx_valid_d;
  logic accept_s, tick_s, div_en_s, active_s;

  assign div_en_s = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
  assign accept_s = host.start && ({1'b0, host.cs_sel} < (CS_W + 1)'(NUM_CS));

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (div_en_s),
    .clr_i   (!div_en_s),
    .tick_o  (tick_s)
  );

  // FSM next state plus shift/sample datapath; phase_q=0 means the next SCK edge is leading.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    cs_d       = cs_q;
    phase_d    = phase_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        sck_d = host.cpol;
        if (accept_s) begin
          state_d = SETUP;
          cs_d    = host.cs_sel;
          cpol_d  = host.cpol;
          cpha_d  = host.cpha;
          bit_d   = BIT_MSB;
          phase_d = 1'b0;
          rx_d    = {DATA_W{1'b0}};
          if (!host.cpha) begin
            mosi_d = host.tx_data[DATA_W-1];
            tx_d   = {host.tx_data[DATA_W-2:0], 1'b0};
          end else begin
            tx_d   = host.tx_data;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) state_d = XFER;
        else        state_d = SETUP;
      end
      XFER: begin
        if (tick_s) begin
          sck_d   = ~sck_q;
          phase_d = ~phase_q;
          if (!phase_q) begin
            if (!cpha_q) begin
              rx_d = {rx_q[DATA_W-2:0], spi_miso};
            end else begin
              mosi_d = tx_q[DATA_W-1];
              tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
            state_d = XFER;
          end else begin
            bit_d = bit_q - BIT_W'(1);
            if (cpha_q) begin
              rx_d = {rx_q[DATA_W-2:0], spi_miso};
            end else if (bit_q != BIT_ZERO) begin
              mosi_d = tx_q[DATA_W-1];
              tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end else begin
              mosi_d = mosi_q;
            end
            if (bit_q == BIT_ZERO) state_d = HOLD;
            else                   state_d = XFER;
          end
        end else begin
          state_d = XFER;
        end
      end
      HOLD: begin
        if (tick_s) state_d = DONE;
        else        state_d = HOLD;
      end
      DONE: begin
        state_d    = IDLE;
        rx_data_d  = rx_q;
        rx_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d   = (state_d != IDLE);
    active_s = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
    for (int i = 0; i < NUM_CS; i++) begin
      csn_d[i] = !(active_s && (cs_d == CS_W'(i)));
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_q       <= {DATA_W{1'b0}};
      rx_q       <= {DATA_W{1'b0}};
      rx_data_q  <= {DATA_W{1'b0}};
      bit_q      <= BIT_ZERO;
      cs_q       <= {CS_W{1'b0}};
      csn_q      <= {NUM_CS{1'b1}};
      phase_q    <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      bit_q      <= bit_d;
      cs_q       <= cs_d;
      csn_q      <= csn_d;
      phase_q    <= phase_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_sck       = sck_q;
  assign spi_mosi      = mosi_q;
  assign spi_csn       = csn_q;
  assign host.busy     = busy_q;
  assign host.rx_valid = rx_valid_q;
  assign host.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: an 8-bit/3-CS/div-2 instance with an SPI
// slave model and a 16-bit/8-CS/div-1 loopback instance.
module tb_spi_master_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  spi_master_gen_if #(.DATA_W(8),  .CS_W(2)) ifa ();
  spi_master_gen_if #(.DATA_W(16), .CS_W(3)) ifb ();

  logic       sck_a, mosi_a, miso_a, lb_a, sl_miso, csn_all_a;
  logic [2:0] csn_a;
  logic       sck_b, mosi_b;
  logic [7:0] csn_b;

  assign miso_a    = lb_a ? mosi_a : sl_miso;
  assign csn_all_a = &csn_a;

  spi_master_gen #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .host(ifa),
    .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_csn(csn_a), .spi_miso(miso_a)
  );

  spi_master_gen #(.DATA_W(16), .NUM_CS(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .host(ifb),
    .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_csn(csn_b), .spi_miso(mosi_b)
  );

  // SPI slave model: returns sl_tx, captures into sl_rx, edges counted while selected.
  logic [7:0] sl_tx = 8'h3C;
  logic [7:0] sl_rx;
  logic       sl_cpha;
  int         sl_cnt;

  always @(negedge csn_all_a) begin
    sl_cnt = 0;
    sl_rx  = 8'h00;
    if (!sl_cpha) sl_miso = sl_tx[7];
  end

  always @(sck_a) begin
    if (!csn_all_a) begin
      sl_cnt++;
      if (sl_cnt % 2 == 1) begin
        if (!sl_cpha) sl_rx = {sl_rx[6:0], mosi_a};
        else          sl_miso = sl_tx[3'(7 - (sl_cnt - 1) / 2)];
      end else begin
        if (sl_cpha)             sl_rx = {sl_rx[6:0], mosi_a};
        else if (sl_cnt / 2 < 8) sl_miso = sl_tx[3'(7 - sl_cnt / 2)];
      end
    end
  end

  task automatic run_a(input logic [7:0] tx, input logic [1:0] cs, input logic cp, input logic ch,
                       output int lat, output logic [7:0] rx, output int vcnt, output int csn_low,
                       output int rises, output logic [2:0] csn_and, output logic sck_pre,
                       output logic sck_post);
    logic prev;
    @(negedge clk);
    ifa.cpol = cp; ifa.cpha = ch; ifa.cs_sel = cs; ifa.tx_data = tx; sl_cpha = ch;
    @(negedge clk);
    @(negedge clk);
    sck_pre = sck_a; prev = sck_a; ifa.start = 1'b1;
    lat = -1; rx = 8'h00; vcnt = 0; csn_low = 0; rises = 0; csn_and = 3'b111;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 0) ifa.start = 1'b0;
      if (csn_a != 3'b111) csn_low++;
      csn_and = csn_and & csn_a;
      if (!prev && sck_a) rises++;
      prev = sck_a;
      if (ifa.rx_valid) begin
        vcnt++;
        if (lat < 0) begin lat = c; rx = ifa.rx_data; end
      end
    end
    sck_post = sck_a;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; lb_a = 1'b1; sl_miso = 1'b0; sl_cpha = 1'b0;
    ifa.start = 1'b0; ifa.tx_data = 8'h00; ifa.cs_sel = 2'd0; ifa.cpol = 1'b1; ifa.cpha = 1'b0;
    ifb.start = 1'b0; ifb.tx_data = 16'h0000; ifb.cs_sel = 3'd0; ifb.cpol = 1'b0; ifb.cpha = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sck_a !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", sck_a); end
    total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi_a); end
    total++; if (csn_a !== 3'b111) begin bad++; $display("FAIL reset_csn got=%b exp=111", csn_a); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifa.busy); end
    total++; if (ifa.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifa.rx_valid); end
    total++; if (ifa.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rxdata got=%h exp=00", ifa.rx_data); end
    total++; if (csn_b !== 8'hFF) begin bad++; $display("FAIL reset_csn_b got=%h exp=ff", csn_b); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sck_a !== 1'b1) begin bad++; $display("FAIL idle_sck_follows_cpol got=%b exp=1", sck_a); end
  endtask

  task automatic test_mode0_loopback();
    int lat, vcnt, low, rises; logic [7:0] rx; logic [2:0] cand; logic pre, post;
    lb_a = 1'b1;
    run_a(8'hA5, 2'd0, 1'b0, 1'b0, lat, rx, vcnt, low, rises, cand, pre, post);
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL m0_rx got=%h exp=a5", rx); end
    total++; if (lat != 37) begin bad++; $display("FAIL m0_latency got=%0d exp=37", lat); end
    total++; if (vcnt != 1) begin bad++; $display("FAIL m0_valid_width got=%0d exp=1", vcnt); end
    total++; if (rises != 8) begin bad++; $display("FAIL m0_sck_rises got=%0d exp=8", rises); end
    total++; if (low != 36) begin bad++; $display("FAIL m0_csn_low got=%0d exp=36", low); end
    total++; if (cand !== 3'b110) begin bad++; $display("FAIL m0_csn_sel got=%b exp=110", cand); end
  endtask

  task automatic test_modes();
    int lat, vcnt, low, rises; logic [7:0] rx; logic [2:0] cand; logic pre, post; logic [1:0] mv;
    lb_a = 1'b0;
    for (int m = 0; m < 4; m++) begin
      mv = 2'(m);
      run_a(8'hC3, 2'd0, mv[1], mv[0], lat, rx, vcnt, low, rises, cand, pre, post);
      total++; if (rx !== 8'h3C) begin bad++; $display("FAIL mode%0d_rx got=%h exp=3c", m, rx); end
      total++; if (sl_rx !== 8'hC3) begin bad++; $display("FAIL mode%0d_slave_rx got=%h exp=c3", m, sl_rx); end
      total++; if (pre !== mv[1]) begin bad++; $display("FAIL mode%0d_sck_pre got=%b exp=%b", m, pre, mv[1]); end
      total++; if (post !== mv[1]) begin bad++; $display("FAIL mode%0d_sck_post got=%b exp=%b", m, post, mv[1]); end
      total++; if (lat != 37) begin bad++; $display("FAIL mode%0d_latency got=%0d exp=37", m, lat); end
    end
  endtask

  task automatic test_cs_select();
    int lat, vcnt, low, rises, odd; logic [7:0] rx; logic [2:0] cand; logic pre, post, mosi0;
    lb_a = 1'b1;
    run_a(8'h69, 2'd2, 1'b0, 1'b0, lat, rx, vcnt, low, rises, cand, pre, post);
    total++; if (cand !== 3'b011) begin bad++; $display("FAIL cs2_only got=%b exp=011", cand); end
    total++; if (rx !== 8'h69) begin bad++; $display("FAIL cs2_rx got=%h exp=69", rx); end
    // cs_sel=3 is out of range on a 3-CS build: nothing may move.
    @(negedge clk);
    ifa.cs_sel = 2'd3; ifa.start = 1'b1; odd = 0; mosi0 = mosi_a;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ifa.busy !== 1'b0 || csn_a !== 3'b111 || sck_a !== 1'b0 || mosi_a !== mosi0) odd++;
    end
    ifa.start = 1'b0;
    total++; if (odd != 0) begin bad++; $display("FAIL cs_out_of_range got=%0d exp=0 moving cycles", odd); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, vcnt, brk, gap; logic [7:0] rx1, rx2; logic busy37; logic [2:0] csn38;
    lb_a = 1'b1;
    @(negedge clk);
    ifa.cpol = 1'b0; ifa.cpha = 1'b0; ifa.cs_sel = 2'd0; ifa.tx_data = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    ifa.start = 1'b1;
    lat1 = -1; lat2 = -1; vcnt = 0; brk = 0; gap = 0; rx1 = 8'h00; rx2 = 8'h00;
    busy37 = 1'bx; csn38 = 3'bxxx;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      ifa.tx_data = 8'(c);
      if (c == 38) ifa.start = 1'b0;
      if (c <= 35 && csn_a[0] !== 1'b0) brk++;
      if ((c == 36 || c == 37) && csn_a === 3'b111) gap++;
      if (c == 37) busy37 = ifa.busy;
      if (c == 38) csn38 = csn_a;
      if (ifa.rx_valid) begin
        vcnt++;
        if (lat1 < 0) begin lat1 = c; rx1 = ifa.rx_data; end
        else if (lat2 < 0) begin lat2 = c; rx2 = ifa.rx_data; end
      end
    end
    total++; if (rx1 !== 8'hA5) begin bad++; $display("FAIL b2b_first_rx got=%h exp=a5", rx1); end
    total++; if (lat1 != 37) begin bad++; $display("FAIL b2b_first_lat got=%0d exp=37", lat1); end
    total++; if (brk != 0) begin bad++; $display("FAIL b2b_no_restart got=%0d exp=0", brk); end
    total++; if (gap != 2) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp=2", gap); end
    total++; if (busy37 !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy37); end
    total++; if (csn38 !== 3'b110) begin bad++; $display("FAIL b2b_restart_csn got=%b exp=110", csn38); end
    total++; if (lat2 != 75) begin bad++; $display("FAIL b2b_second_lat got=%0d exp=75", lat2); end
    total++; if (rx2 !== 8'h25) begin bad++; $display("FAIL b2b_second_rx got=%h exp=25", rx2); end
    total++; if (vcnt != 2) begin bad++; $display("FAIL b2b_valid_count got=%0d exp=2", vcnt); end
  endtask

  task automatic test_reset_mid();
    int lat, vcnt, low, rises, rv; logic [7:0] rx; logic [2:0] cand; logic pre, post, sck_before;
    lb_a = 1'b1;
    @(negedge clk);
    ifa.cpol = 1'b1; ifa.cpha = 1'b1; ifa.cs_sel = 2'd1; ifa.tx_data = 8'h96;
    @(negedge clk);
    @(negedge clk);
    ifa.start = 1'b1; rv = 0;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c == 0) ifa.start = 1'b0;
      if (ifa.rx_valid) rv++;
    end
    sck_before = sck_a;
    reset_n = 1'b0;
    #1;
    total++; if (sck_before !== 1'b1) begin bad++; $display("FAIL rstmid_sck_before got=%b exp=1", sck_before); end
    total++; if (csn_a !== 3'b111) begin bad++; $display("FAIL rstmid_csn got=%b exp=111", csn_a); end
    total++; if (sck_a !== 1'b0) begin bad++; $display("FAIL rstmid_sck got=%b exp=0", sck_a); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", ifa.busy); end
    repeat (3) begin @(negedge clk); if (ifa.rx_valid) rv++; end
    reset_n = 1'b1;
    repeat (40) begin @(negedge clk); if (ifa.rx_valid) rv++; end
    total++; if (rv != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", rv); end
    run_a(8'h5A, 2'd0, 1'b0, 1'b0, lat, rx, vcnt, low, rises, cand, pre, post);
    total++; if (rx !== 8'h5A) begin bad++; $display("FAIL rstmid_after_rx got=%h exp=5a", rx); end
    total++; if (lat != 37) begin bad++; $display("FAIL rstmid_after_lat got=%0d exp=37", lat); end
  endtask

  task automatic test_wide();
    int lat; logic [15:0] rx; logic [7:0] cand; logic mosi0, mosi3;
    @(negedge clk);
    ifb.cpol = 1'b0; ifb.cpha = 1'b0; ifb.cs_sel = 3'd5; ifb.tx_data = 16'h8001;
    @(negedge clk);
    ifb.start = 1'b1; lat = -1; rx = 16'h0000; cand = 8'hFF; mosi0 = 1'bx; mosi3 = 1'bx;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (c == 0) begin ifb.start = 1'b0; mosi0 = mosi_b; end
      if (c == 3) mosi3 = mosi_b;
      cand = cand & csn_b;
      if (ifb.rx_valid && lat < 0) begin lat = c; rx = ifb.rx_data; end
    end
    total++; if (rx !== 16'h8001) begin bad++; $display("FAIL wide_rx got=%h exp=8001", rx); end
    total++; if (lat != 35) begin bad++; $display("FAIL wide_latency got=%0d exp=35", lat); end
    total++; if (cand !== 8'hDF) begin bad++; $display("FAIL wide_cs5 got=%h exp=df", cand); end
    total++; if (mosi0 !== 1'b1) begin bad++; $display("FAIL wide_msb_first got=%b exp=1", mosi0); end
    total++; if (mosi3 !== 1'b0) begin bad++; $display("FAIL wide_second_bit got=%b exp=0", mosi3); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_cs_select();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
